// File: rtl/dco_pkg.sv
// Shared types and helpers for the ring-DCO front-end.
package dco_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_START  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } dco_state_e;

  // Widest stage-control bus the thermometer helper can produce.
  localparam int unsigned THERM_MAX_W = 256;

  // Binary count -> thermometer fill: bit i set iff i < cnt.
  function automatic logic [THERM_MAX_W-1:0] therm_encode(input int unsigned cnt);
    logic [THERM_MAX_W-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < THERM_MAX_W; i++) t[i] = (i < cnt);
    return t;
  endfunction

  // Clamp v to at most hi.
  function automatic int unsigned sat_clamp(input int unsigned v, input int unsigned hi);
    return (v > hi) ? hi : v;
  endfunction

  // Elaboration-time sanity of the parameter set.
  function automatic bit params_ok(input int n_ph, input int ctrl_w,
                                   input int code_w, input int settle);
    return (n_ph >= 3) && (n_ph % 2 == 1) &&
           (ctrl_w >= 1) && (ctrl_w <= int'(THERM_MAX_W)) &&
           (code_w >= 1) && (code_w < 31) &&
           ((1 << code_w) > ctrl_w) && ((1 << code_w) >= 2 * n_ph) &&
           (settle >= 1);
  endfunction

endpackage

// File: rtl/dco_phase_decode.sv
// Synchronises the ring taps and decodes them into a phase index.
module dco_phase_decode
  import dco_pkg::*;
#(
  parameter int N_PH  = 3,
  parameter int IDX_W = 7
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             en_i,      // snapshot is qualified: update err/err_cnt
  input  logic             clr_i,     // clear the error counter
  input  logic [N_PH-1:0]  ck_i,
  output logic [N_PH-1:0]  ph_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             err_o,
  output logic [7:0]       err_cnt_o
);

  logic [N_PH-1:0]  sync1_q, sync2_q, ph_q;
  logic [IDX_W-1:0] idx_q, hit;
  logic             err_q, legal;
  logic [7:0]       cnt_q;
  int unsigned      n_eq;

  // Two-flop synchroniser for the asynchronous ring taps.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ck_i;
      sync2_q <= sync1_q;
    end
  end

  // Legal iff exactly one cyclic neighbour pair is equal; that pair names the phase.
  always_comb begin
    n_eq = 0;
    hit  = '0;
    for (int unsigned i = 0; i < N_PH; i++) begin
      if (sync2_q[i] == sync2_q[(i + 1) % N_PH]) begin
        n_eq = n_eq + 1;
        hit  = IDX_W'(sync2_q[i] ? i + N_PH : i);
      end
    end
    legal = (n_eq == 1);
  end

  // Decode register: snapshot, index (held on illegal), error flag and saturating count.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      ph_q  <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ph_q <= sync2_q;
      if (legal) idx_q <= hit;
      if (en_i) err_q <= ~legal;
      if (clr_i)                              cnt_q <= '0;
      else if (en_i && !legal && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign ph_o      = ph_q;
  assign idx_o     = idx_q;
  assign err_o     = err_q;
  assign err_cnt_o = cnt_q;

endmodule

// File: rtl/dco_ctrl_sampler.sv
// Ring-DCO front-end: enable sequencing, slew-limited thermometer control,
// code handshake, and the synchronised phase decode path.
module dco_ctrl_sampler
  import dco_pkg::*;
#(
  parameter int N_PH       = 3,
  parameter int CTRL_W     = 64,
  parameter int CODE_W     = 7,
  parameter int START_CODE = 32,
  parameter int STEP_MAX   = 4,
  parameter int SETTLE_CYC = 16
) (
  input  logic              refclk,
  input  logic              reset,
  input  logic              enable_in,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic [N_PH-1:0]   ck_in,
  output logic              enable,
  output logic [CTRL_W-1:0] ctrl,
  output logic [N_PH-1:0]   ph,
  output logic [CODE_W-1:0] ph_idx,
  output logic              ph_valid,
  output logic              ph_err,
  output logic [7:0]        err_cnt,
  output logic [1:0]        state
);

  if (!params_ok(N_PH, CTRL_W, CODE_W, SETTLE_CYC)) begin : g_bad_params
    $error("dco_ctrl_sampler: illegal parameter set");
  end

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CODE_W-1:0] LOAD_CODE = CODE_W'(sat_clamp(START_CODE, CTRL_W));
  localparam logic [CODE_W-1:0] STEP      = CODE_W'(STEP_MAX);

  dco_state_e        state_q, state_d;
  logic [CODE_W-1:0] app_q, app_d, tgt_q, tgt_d, slew;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [1:0]        age_q, age_d;     // RUN cycles seen, saturating at 2
  logic              enable_q, enable_d;
  logic              ready_q, ready_d;
  logic              pv_q, pv_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              err_clr;

  // State register.
  always_ff @(posedge refclk or negedge reset) begin
    if (!reset) state_q <= ST_OFF;
    else        state_q <= state_d;
  end

  // Next state: dropping enable_in wins over everything else.
  always_comb begin
    state_d = state_q;
    if (!enable_in) state_d = ST_OFF;
    else begin
      case (state_q)
        ST_OFF:    state_d = ST_START;
        ST_START:  state_d = ST_SETTLE;
        ST_SETTLE: if (settle_q == SET_W'(SETTLE_CYC - 1)) state_d = ST_RUN;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  // One slew step of the applied code toward the current target.
  always_comb begin
    slew = app_q;
    if (tgt_q > app_q)      slew = (tgt_q - app_q > STEP) ? app_q + STEP : tgt_q;
    else if (app_q > tgt_q) slew = (app_q - tgt_q > STEP) ? app_q - STEP : tgt_q;
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    app_d    = app_q;
    tgt_d    = tgt_q;
    settle_d = settle_q;
    age_d    = age_q;
    if (!enable_in) begin
      app_d = '0;
      tgt_d = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          app_d = LOAD_CODE;
          tgt_d = LOAD_CODE;
        end
        ST_START:  settle_d = '0;
        ST_SETTLE: begin
          settle_d = settle_q + SET_W'(1);
          age_d    = 2'd0;
        end
        default: begin
          app_d = slew;
          // ready_q already implies RUN with applied == target
          if (code_valid && ready_q) tgt_d = CODE_W'(sat_clamp(32'(code_in), CTRL_W));
          if (age_q != 2'd2) age_d = age_q + 2'd1;
        end
      endcase
    end
    enable_d = (state_d != ST_OFF);
    ready_d  = (state_d == ST_RUN) && (app_d == tgt_d);
    pv_d     = (state_d == ST_RUN) && (state_q == ST_RUN) && (age_q == 2'd2);
    ctrl_d   = CTRL_W'(therm_encode(32'(app_d)));
    err_clr  = (state_q == ST_OFF) && (state_d == ST_START);
  end

  // Datapath and output registers.
  always_ff @(posedge refclk or negedge reset) begin
    if (!reset) begin
      app_q    <= '0;
      tgt_q    <= '0;
      settle_q <= '0;
      age_q    <= '0;
      enable_q <= 1'b0;
      ready_q  <= 1'b0;
      pv_q     <= 1'b0;
      ctrl_q   <= '0;
    end else begin
      app_q    <= app_d;
      tgt_q    <= tgt_d;
      settle_q <= settle_d;
      age_q    <= age_d;
      enable_q <= enable_d;
      ready_q  <= ready_d;
      pv_q     <= pv_d;
      ctrl_q   <= ctrl_d;
    end
  end

  dco_phase_decode #(
    .N_PH  (N_PH),
    .IDX_W (CODE_W)
  ) u_phase (
    .gclk      (refclk),
    .grst_n    (reset),
    .en_i      (pv_d),
    .clr_i     (err_clr),
    .ck_i      (ck_in),
    .ph_o      (ph),
    .idx_o     (ph_idx),
    .err_o     (ph_err),
    .err_cnt_o (err_cnt)
  );

  assign state      = state_q;
  assign enable     = enable_q;
  assign ctrl       = ctrl_q;
  assign code_ready = ready_q;
  assign ph_valid   = pv_q;

endmodule

// File: tb/tb_dco_ctrl_sampler.sv
// Directed bench for dco_ctrl_sampler with a cycle-level behavioural model.
module tb_dco_ctrl_sampler;

  logic        refclk = 1'b0;
  logic        rst_n;
  logic        enable_in, code_valid;
  logic [6:0]  code_in;
  logic [2:0]  ck_in;
  logic        code_ready, enable, ph_valid, ph_err;
  logic [63:0] ctrl;
  logic [2:0]  ph;
  logic [6:0]  ph_idx;
  logic [7:0]  err_cnt;
  logic [1:0]  state;

  int n_chk = 0;
  int n_err = 0;

  always #5 refclk = ~refclk;

  dco_ctrl_sampler dut (
    .refclk(refclk), .reset(rst_n), .enable_in(enable_in), .code_in(code_in),
    .code_valid(code_valid), .code_ready(code_ready), .ck_in(ck_in),
    .enable(enable), .ctrl(ctrl), .ph(ph), .ph_idx(ph_idx), .ph_valid(ph_valid),
    .ph_err(ph_err), .err_cnt(err_cnt), .state(state)
  );

  function automatic logic [63:0] th(input int n);
    return (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_state, m_app, m_tgt, m_left, m_age, m_idx, m_cnt;
  bit         m_err, m_xfer;
  logic [2:0] h0, h1, h2, m_ph;
  int         eqs, eq_at;

  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_app = 0; m_tgt = 0; m_left = 0; m_age = 0;
      m_idx = 0; m_cnt = 0; m_err = 0; h0 = 0; h1 = 0; h2 = 0; m_ph = 0;
    end else begin
      if (!enable_in) begin
        m_state = 0; m_app = 0; m_tgt = 0;
      end else if (m_state == 0) begin
        m_state = 1; m_app = 32; m_tgt = 32; m_cnt = 0;
      end else if (m_state == 1) begin
        m_state = 2; m_left = 16;
      end else if (m_state == 2) begin
        m_left--;
        if (m_left == 0) begin m_state = 3; m_age = 0; end
      end else begin
        m_xfer = code_valid && (m_app == m_tgt);
        if (m_tgt > m_app)      m_app += (m_tgt - m_app < 4) ? m_tgt - m_app : 4;
        else if (m_app > m_tgt) m_app -= (m_app - m_tgt < 4) ? m_app - m_tgt : 4;
        if (m_xfer) m_tgt = (int'(code_in) > 64) ? 64 : int'(code_in);
        m_age++;
      end
      // phase path: three-deep history of sampled taps
      h2 = h1; h1 = h0; h0 = ck_in; m_ph = h2;
      eqs = 0; eq_at = 0;
      for (int i = 0; i < 3; i++)
        if (m_ph[i] == m_ph[(i + 1) % 3]) begin eqs++; eq_at = i; end
      if (eqs == 1) m_idx = eq_at + 3 * int'(m_ph[eq_at]);
      if (m_state == 3 && m_age >= 3) begin
        m_err = (eqs != 1);
        if (m_err && m_cnt < 255) m_cnt++;
      end
    end
  end

  // Compare every cycle away from the active edge.
  always @(negedge refclk) begin
    chk("state",      64'(state),      64'(m_state));
    chk("enable",     64'(enable),     64'(m_state != 0));
    chk("ctrl",       ctrl,            th(m_app));
    chk("code_ready", 64'(code_ready), 64'(m_state == 3 && m_app == m_tgt));
    chk("ph",         64'(ph),         64'(m_ph));
    chk("ph_idx",     64'(ph_idx),     64'(m_idx));
    chk("ph_valid",   64'(ph_valid),   64'(m_state == 3 && m_age >= 3));
    chk("ph_err",     64'(ph_err),     64'(m_err));
    chk("err_cnt",    64'(err_cnt),    64'(m_cnt));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge refclk); #1; end
  endtask

  task automatic xfer(input int c);
    code_in = 7'(c); code_valid = 1'b1;
    tick(1);
    code_valid = 1'b0;
  endtask

  int         slew45 [4] = '{36, 40, 44, 45};
  logic [2:0] pats   [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
  int         idxs   [6] = '{1, 3, 2, 4, 0, 5};

  initial begin
    rst_n = 1'b0; enable_in = 1'b0; code_valid = 1'b0; code_in = '0; ck_in = 3'b101;
    tick(2);
    chk("rst_state", 64'(state), 0);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_enable", 64'(enable), 0);
    rst_n = 1'b1;
    tick(1);

    // start-up sequence
    enable_in = 1'b1;
    tick(1); chk("lit_start", 64'(state), 1);
    tick(1); chk("lit_settle", 64'(state), 2);
    chk("lit_ctrl32", ctrl, 64'h0000_0000_FFFF_FFFF);
    tick(15); chk("lit_still_settle", 64'(state), 2);
    tick(1); chk("lit_run", 64'(state), 3);
    chk("lit_ready_run", 64'(code_ready), 1);

    // slew to 45
    xfer(45);
    chk("lit_ready_drop", 64'(code_ready), 0);
    chk("lit_ctrl_hold", ctrl, th(32));
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("lit_slew45", ctrl, th(slew45[k]));
      chk("lit_ready45", 64'(code_ready), 64'(k == 3));
    end

    // back to 32, then saturate upward, then drain to 0
    xfer(32); tick(4); chk("lit_back32", ctrl, th(32));
    xfer(100); tick(7); chk("lit_sat_pre", ctrl, th(60));
    tick(1); chk("lit_all_ones", ctrl, {64{1'b1}});
    xfer(0); tick(15); chk("lit_drain_pre", ctrl, th(4));
    tick(1); chk("lit_zero", ctrl, 0);
    chk("lit_ready0", 64'(code_ready), 1);

    // phase decode, 3-edge latency
    for (int k = 0; k < 6; k++) begin
      ck_in = pats[k];
      tick(3);
      chk("lit_ph", 64'(ph), 64'(pats[k]));
      chk("lit_ph_idx", 64'(ph_idx), 64'(idxs[k]));
      chk("lit_ph_err", 64'(ph_err), 0);
      tick(1);
    end

    // illegal snapshots: saturating error count, frozen index
    ck_in = 3'b111;
    tick(300);
    chk("lit_err_sat", 64'(err_cnt), 255);
    chk("lit_err_flag", 64'(ph_err), 1);
    chk("lit_idx_frozen", 64'(ph_idx), 5);
    enable_in = 1'b0; tick(1); chk("lit_off", 64'(state), 0);
    enable_in = 1'b1; ck_in = 3'b001;
    tick(1); chk("lit_errcnt_clr", 64'(err_cnt), 0);

    // disable mid-slew with a same-cycle code_valid
    tick(17); chk("lit_run2", 64'(state), 3);
    xfer(60); tick(2);
    enable_in = 1'b0; code_valid = 1'b1; code_in = 7'd10;
    tick(1);
    code_valid = 1'b0;
    chk("lit_kill_state", 64'(state), 0);
    chk("lit_kill_en", 64'(enable), 0);
    chk("lit_kill_ctrl", ctrl, 0);
    enable_in = 1'b1;
    tick(2); chk("lit_restart_ctrl", ctrl, th(32));

    // disable on the SETTLE->RUN edge
    tick(15); enable_in = 1'b0;
    tick(1); chk("lit_settle_kill", 64'(state), 0);

    // async reset mid-RUN
    enable_in = 1'b1;
    tick(18); chk("lit_run3", 64'(state), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", 64'(state), 0);
    chk("async_enable", 64'(enable), 0);
    chk("async_ctrl", ctrl, 0);
    chk("async_ready", 64'(code_ready), 0);
    chk("async_ph", 64'(ph), 0);
    chk("async_ph_valid", 64'(ph_valid), 0);
    chk("async_err_cnt", 64'(err_cnt), 0);
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
